adc_ascii_streamer: RTL and testbench
=====================================

// Module: adc_ascii_streamer
// PURPOSE
//  Periodic or on-demand serializer of NUM_CH BCD readings (e.g. XADC sseg_data) to ASCII
//  bytes for the UART transmitter, e.g. "0.734\r\n". Snapshots all channels at frame start,
//  inserts decimal point/separators/CR LF, and feeds bytes over a valid/ready handshake.
//  Sits between XADC/BCD conversion and the transmitter in top-level designs.
// PARAMETERS
//  NUM_CH        1      channels per frame (1..8), channel 0 sent first
//  NUM_DIGITS    4      BCD digits per channel (1..8), most significant nibble first
//  DP_POS        3      fractional digits; '.' precedes last DP_POS digits; 0 = no point; < NUM_DIGITS
//  PERIOD_CYCLES 65536  clk cycles between automatic frame requests (>= 2)
//  SEP_CHAR      8'h2C  byte sent between channels (',')
// PORTS
//  clk       in   1                     system clock (100 MHz)
//  reset     in   1                     synchronous, active-low reset
//  enable    in   1                     1 = periodic frames allowed
//  force_req in   1                     single-cycle pulse: request one frame (debounced button)
//  bcd_data  in   NUM_CH*NUM_DIGITS*4   BCD readings, ch0 in LSBs
//  tx_data   out  8                     ASCII byte to transmitter
//  tx_valid  out  1                     tx_data valid
//  tx_ready  in   1                     transmitter accepts byte this cycle
//  busy      out  1                     frame in progress (LOAD..LF)
//  frame_done out 1                     1-cycle pulse after LF accepted
//  snapshot  out  NUM_DIGITS*4          latched ch0 reading (LED display)
// BEHAVIOUR
//  - reset==0 at posedge: state IDLE, tx_valid=0, tx_data=8'h00, busy=0, frame_done=0,
//    snapshot=0, period counter=0, pending=0. Mid-frame reset aborts: tx_valid low next cycle.
//  - Period counter free-runs 0..PERIOD_CYCLES-1; wrap while enable=1 sets pending.
//    force_req=1 sets pending regardless of enable. Tick+req same cycle -> one pending.
//    Pending is 1-deep: requests during busy merge, never queue >1 frame.
//  - FSM: IDLE -(pending)-> LOAD -> DIGIT -> [DOT] -> DIGIT.. -> [SEP -> DIGIT..] -> CR -> LF -> IDLE.
//    LOAD (1 cycle): latch bcd_data to internal snapshot, clear pending, update snapshot port.
//    Per channel: digits MS-first; '.' (8'h2E) after NUM_DIGITS-DP_POS digits if DP_POS>0.
//    SEP_CHAR between channels only (not after last). Then 8'h0D, 8'h0A.
//  - Digit encoding: nibble 0..9 -> {4'h3,nibble}; nibble A..F -> 8'h3F ('?').
//  - Handshake: tx_valid asserted first cycle after LOAD; tx_data stable while tx_valid && !tx_ready;
//    transfer on tx_valid && tx_ready; next byte presented the following cycle (valid may stay high).
//    No byte dropped or duplicated; tx_ready ignored when tx_valid=0.
//  - Frame bytes = NUM_CH*(NUM_DIGITS+(DP_POS>0)) + (NUM_CH-1) + 2 (default 7).
//  - Latency: pending set -> LOAD next cycle (if IDLE) -> first tx_valid one cycle later.
//  - bcd_data changes during frame have no effect on current frame.
//  - frame_done pulses the cycle after LF transfer; pending may start LOAD that same cycle.
//  - enable falling mid-frame: current frame completes; no new periodic requests.
// CONFIGURATION
//  CHANNEL_TAG_EN defined: each channel prefixed by 'A'+ch and ':' (ch0 "A:", ch1 "B:");
//    adds 2*NUM_CH bytes/frame. Undefined: no prefix, byte count as above.
// TESTING
//  1 defaults, bcd_data=16'h0734, force_req pulse, tx_ready=1 -> 30 2E 37 33 34 0D 0A, frame_done once.
//  2 tx_ready toggled 1-of-3 cycles -> same 7 bytes, tx_data stable while stalled, no dup/drop.
//  3 NUM_CH=2, DP_POS=0, bcd_data=32'h1234_0099 -> "0099,1234\r\n" (11 bytes).
//  4 nibble 4'hB in digit 2 -> byte 8'h3F in that position; other bytes unchanged.
//  5 PERIOD_CYCLES=100, enable=1, tx_ready=1 -> frame every 100 cycles; force_req during busy -> exactly
//    one extra frame; enable=0 -> no periodic frames.
//  6 reset low mid-frame (after byte 3) -> tx_valid=0, busy=0 next cycle; next request restarts at byte 1.
//  7 CHANNEL_TAG_EN, defaults, 16'h0734 -> 41 3A 30 2E 37 33 34 0D 0A.

Source files
------------

// File: rtl/adc_ascii_streamer.sv
// ============================================================================
// adc_ascii_streamer: snapshots NUM_CH BCD readings and streams them as ASCII
// bytes over valid/ready. Optional macro CHANNEL_TAG_EN adds "A:"-style tags.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module adc_ascii_streamer #(
  parameter int          NUM_CH        = 1,
  parameter int          NUM_DIGITS    = 4,
  parameter int          DP_POS        = 3,
  parameter int          PERIOD_CYCLES = 65536,
  parameter logic [7:0]  SEP_CHAR      = 8'h2C
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         force_req,
  input  logic [NUM_CH*NUM_DIGITS*4-1:0] bcd_data,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic [NUM_DIGITS*4-1:0]      snapshot
);

  localparam int              DW       = NUM_CH*NUM_DIGITS*4;
  localparam int              CNTW     = $clog2(PERIOD_CYCLES);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(PERIOD_CYCLES-1);
  localparam bit              HAS_DOT  = (DP_POS > 0);
  localparam logic [2:0]      DOT_DIG  = 3'(NUM_DIGITS-DP_POS-1);
  localparam logic [2:0]      LAST_DIG = 3'(NUM_DIGITS-1);
  localparam logic [2:0]      LAST_CH  = 3'(NUM_CH-1);
`ifdef CHANNEL_TAG_EN
  localparam bit              TAG_EN   = 1'b1;
`else
  localparam bit              TAG_EN   = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_TAG, S_COLON, S_DIGIT, S_DOT, S_SEP, S_CR, S_LF
  } state_t;

  state_t          state, nxt_state;
  logic [CNTW-1:0] cnt;
  logic            pending;
  logic [DW-1:0]   snap_all;
  logic [2:0]      ch, nxt_ch;
  logic [2:0]      dig, nxt_dig;
  logic [7:0]      nxt_byte;
  logic [DW-1:0]   src;
  logic [3:0]      nib;
  int              base;

  function automatic logic [7:0] enc_digit(input logic [3:0] n);
    return (n <= 4'd9) ? {4'h3, n} : 8'h3F;
  endfunction

  // Request tracking: a new request in the same cycle as LOAD wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      if (((cnt == CNT_MAX) && enable) || force_req)
        pending <= 1'b1;
      else if (state == S_LOAD)
        pending <= 1'b0;
    end
  end

  // Successor of the byte currently presented, and the byte it produces.
  always_comb begin
    nxt_state = state;
    nxt_ch    = ch;
    nxt_dig   = dig;
    case (state)
      S_LOAD: begin
        nxt_ch    = 3'd0;
        nxt_dig   = 3'd0;
        nxt_state = TAG_EN ? S_TAG : S_DIGIT;
      end
      S_TAG:   nxt_state = S_COLON;
      S_COLON: begin
        nxt_state = S_DIGIT;
        nxt_dig   = 3'd0;
      end
      S_DIGIT: begin
        if (HAS_DOT && (dig == DOT_DIG))
          nxt_state = S_DOT;
        else if (dig == LAST_DIG)
          nxt_state = (ch == LAST_CH) ? S_CR : S_SEP;
        else
          nxt_dig = dig + 3'd1;
      end
      S_DOT: begin
        nxt_state = S_DIGIT;
        nxt_dig   = dig + 3'd1;
      end
      S_SEP: begin
        nxt_ch    = ch + 3'd1;
        nxt_dig   = 3'd0;
        nxt_state = TAG_EN ? S_TAG : S_DIGIT;
      end
      S_CR:    nxt_state = S_LF;
      S_LF:    nxt_state = pending ? S_LOAD : S_IDLE;
      default: nxt_state = state;
    endcase

    // During LOAD the snapshot register is not yet written, so read the live input.
    src  = (state == S_LOAD) ? bcd_data : snap_all;
    base = (int'(nxt_ch) * NUM_DIGITS + (NUM_DIGITS - 1 - int'(nxt_dig))) * 4;
    nib  = 4'(src >> base);

    case (nxt_state)
      S_TAG:   nxt_byte = 8'h41 + {5'd0, nxt_ch};
      S_COLON: nxt_byte = 8'h3A;
      S_DIGIT: nxt_byte = enc_digit(nib);
      S_DOT:   nxt_byte = 8'h2E;
      S_SEP:   nxt_byte = SEP_CHAR;
      S_CR:    nxt_byte = 8'h0D;
      S_LF:    nxt_byte = 8'h0A;
      default: nxt_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      ch         <= 3'd0;
      dig        <= 3'd0;
      snap_all   <= '0;
      snapshot   <= '0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pending) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          snap_all <= bcd_data;
          snapshot <= bcd_data[NUM_DIGITS*4-1:0];
          state    <= nxt_state;
          ch       <= nxt_ch;
          dig      <= nxt_dig;
          tx_data  <= nxt_byte;
          tx_valid <= 1'b1;
        end
        default: begin
          if (tx_valid && tx_ready) begin
            state <= nxt_state;
            ch    <= nxt_ch;
            dig   <= nxt_dig;
            if (state == S_LF) begin
              frame_done <= 1'b1;
              tx_valid   <= 1'b0;
              busy       <= pending;
            end else begin
              tx_data <= nxt_byte;
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_ascii_streamer.sv
// ============================================================================
// tb_adc_ascii_streamer: directed vectors for adc_ascii_streamer (two instances)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adc_ascii_streamer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: one channel, default format, short period
  logic        r0 = 1'b0, en0 = 1'b0, frc0 = 1'b0, rdy0 = 1'b0;
  logic [15:0] bcd0 = 16'h0000;
  logic [7:0]  d0;
  logic        v0, busy0, done0;
  logic [15:0] snap0;

  // dut1: two channels, no decimal point
  logic        r1 = 1'b0, en1 = 1'b0, frc1 = 1'b0, rdy1 = 1'b0;
  logic [31:0] bcd1 = 32'h0;
  logic [7:0]  d1;
  logic        v1, busy1, done1;
  logic [15:0] snap1;

  adc_ascii_streamer #(.PERIOD_CYCLES(100)) dut0 (
    .clk(clk), .reset(r0), .enable(en0), .force_req(frc0), .bcd_data(bcd0),
    .tx_data(d0), .tx_valid(v0), .tx_ready(rdy0), .busy(busy0),
    .frame_done(done0), .snapshot(snap0)
  );

  adc_ascii_streamer #(.NUM_CH(2), .DP_POS(0)) dut1 (
    .clk(clk), .reset(r1), .enable(en1), .force_req(frc1), .bcd_data(bcd1),
    .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1), .busy(busy1),
    .frame_done(done1), .snapshot(snap1)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_b [16];
  int exp_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_exp(input logic [8*16-1:0] bytes, input int n);
    exp_n = n;
    for (int i = 0; i < n; i++) exp_b[i] = bytes[8*(n-1-i) +: 8];
  endtask

  // Background monitor of dut0 frame starts / completions, sampled after the edge.
  int cyc = 0, starts0 = 0, dones0 = 0, last_start = 0;
  logic busy0_q = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (busy0 && !busy0_q) begin
      starts0++;
      last_start = cyc;
    end
    if (done0) dones0++;
    busy0_q = busy0;
  end

  task automatic pulse_force(input int sel);
    @(negedge clk);
    if (sel != 0) frc1 = 1'b1; else frc0 = 1'b1;
    @(negedge clk);
    frc0 = 1'b0;
    frc1 = 1'b0;
  endtask

  // Receive one frame; mode 1 accepts only every third cycle.
  task automatic run_frame(input int sel, input int mode, input string name);
    int got = 0, dones = 0, k = 0;
    bit stalled = 0;
    logic [7:0] held = 8'h00, dd;
    logic vv, fd, rdy;
    while (dones == 0 && k < 200) begin
      @(negedge clk);
      k++;
      vv = (sel != 0) ? v1 : v0;
      dd = (sel != 0) ? d1 : d0;
      fd = (sel != 0) ? done1 : done0;
      if (fd) dones++;
      rdy = 1'b0;
      if (vv) begin
        if (stalled) check($sformatf("%s_stable%0d", name, got), {24'd0, dd}, {24'd0, held});
        rdy = (mode == 0) ? 1'b1 : (k % 3 == 0);
        if (rdy) begin
          if (got < exp_n) check($sformatf("%s_b%0d", name, got), {24'd0, dd}, {24'd0, exp_b[got]});
          got++;
          stalled = 0;
          if (got == 2) begin
            bcd0 = 16'h9999;
            bcd1 = 32'h9999_9999;
          end
        end else begin
          stalled = 1;
          held = dd;
        end
      end
      rdy0 = rdy;
      rdy1 = rdy;
    end
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ((sel != 0) ? done1 : done0) dones++;
      if ((sel != 0) ? v1 : v0) got++;
    end
    check({name, "_count"}, got, exp_n);
    check({name, "_done"}, dones, 1);
    check({name, "_idle"}, {31'd0, (sel != 0) ? busy1 : busy0}, 0);
  endtask

  task automatic wait_start(input string name, output int t);
    int s = starts0;
    int k = 0;
    while (starts0 == s && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, "_seen"}, {31'd0, starts0 != s}, 1);
    t = last_start;
  endtask

  initial begin
    int t1, t2, dsnap, got, k;

    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, v0}, 0);
    check("rst_data", {24'd0, d0}, 0);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_done", {31'd0, done0}, 0);
    check("rst_snap", {16'd0, snap0}, 0);
    r0 = 1'b1;
    r1 = 1'b1;
    @(negedge clk);

    // 1: basic frame and request latency
    bcd0 = 16'h0734;
`ifdef CHANNEL_TAG_EN
    load_exp(128'({8'h41, 8'h3A, 8'h30, 8'h2E, 8'h37, 8'h33, 8'h34, 8'h0D, 8'h0A}), 9);
`else
    load_exp(128'({8'h30, 8'h2E, 8'h37, 8'h33, 8'h34, 8'h0D, 8'h0A}), 7);
`endif
    pulse_force(0);
    check("lat_pend_valid", {31'd0, v0}, 0);
    check("lat_pend_busy", {31'd0, busy0}, 0);
    @(negedge clk);
    check("lat_load_busy", {31'd0, busy0}, 1);
    check("lat_load_valid", {31'd0, v0}, 0);
    run_frame(0, 0, "t1");
    check("t1_snap", {16'd0, snap0}, 32'h0734);

    // 2: back-pressure
    bcd0 = 16'h0734;
    pulse_force(0);
    run_frame(0, 1, "t2");

    // 3: two channels, no point
    bcd1 = 32'h1234_0099;
`ifdef CHANNEL_TAG_EN
    load_exp(128'({8'h41, 8'h3A, 8'h30, 8'h30, 8'h39, 8'h39, 8'h2C, 8'h42, 8'h3A,
                   8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}), 15);
`else
    load_exp(128'({8'h30, 8'h30, 8'h39, 8'h39, 8'h2C, 8'h31, 8'h32, 8'h33, 8'h34,
                   8'h0D, 8'h0A}), 11);
`endif
    pulse_force(1);
    run_frame(1, 0, "t3");
    check("t3_snap", {16'd0, snap1}, 32'h0099);

    // 4: non-decimal nibble becomes '?'
    bcd0 = 16'h07B4;
`ifdef CHANNEL_TAG_EN
    load_exp(128'({8'h41, 8'h3A, 8'h30, 8'h2E, 8'h37, 8'h3F, 8'h34, 8'h0D, 8'h0A}), 9);
`else
    load_exp(128'({8'h30, 8'h2E, 8'h37, 8'h3F, 8'h34, 8'h0D, 8'h0A}), 7);
`endif
    pulse_force(0);
    run_frame(0, 0, "t4");
    check("t4_snap", {16'd0, snap0}, 32'h07B4);

    // 5: periodic frames, merged force, enable off
    rdy0 = 1'b1;
    en0  = 1'b1;
    wait_start("t5_first", t1);
    wait_start("t5_second", t2);
    check("t5_period", t2 - t1, 100);
    dsnap = dones0;
    @(negedge clk); frc0 = 1'b1;
    @(negedge clk); frc0 = 1'b0;
    @(negedge clk); frc0 = 1'b1;
    @(negedge clk); frc0 = 1'b0;
    repeat (76) @(negedge clk);
    check("t5_extra", dones0 - dsnap, 2);
    en0 = 1'b0;
    dsnap = dones0;
    repeat (250) @(negedge clk);
    check("t5_disabled", dones0 - dsnap, 0);
    rdy0 = 1'b0;

    // 6: reset mid-frame, then a clean restart
    bcd0 = 16'h0734;
`ifdef CHANNEL_TAG_EN
    load_exp(128'({8'h41, 8'h3A, 8'h30, 8'h2E, 8'h37, 8'h33, 8'h34, 8'h0D, 8'h0A}), 9);
`else
    load_exp(128'({8'h30, 8'h2E, 8'h37, 8'h33, 8'h34, 8'h0D, 8'h0A}), 7);
`endif
    rdy0 = 1'b1;
    pulse_force(0);
    got = 0;
    k = 0;
    while (got < 3 && k < 50) begin
      @(negedge clk);
      k++;
      if (v0) got++;
    end
    check("t6_reached3", got, 3);
    @(negedge clk);
    r0 = 1'b0;
    @(negedge clk);
    check("t6_valid", {31'd0, v0}, 0);
    check("t6_busy", {31'd0, busy0}, 0);
    r0 = 1'b1;
    rdy0 = 1'b0;
    @(negedge clk);
    pulse_force(0);
    run_frame(0, 0, "t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
